uni_register_seq: RTL and testbench

Command sequencer for the 4-bit universal shift register. It accepts one command at a time over a valid/ready handshake and drives the register's `modo`, `serder`, `serizq` and `entparalela` inputs for the required number of cycles. It reports completion with a one-cycle `done` pulse. It sits between a bus-side or FSM-side requester and the register, so requesters never drive mode lines directly.

---
 rtl/uni_register_seq.sv | 167 ++++++++++++++++
 tb/tb_uni_register_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uni_register_seq.sv
// Command sequencer for a 4-bit universal shift register: accepts one command at a time
// and drives the register's mode, serial and parallel inputs for the required cycles.
// state | meaning
// IDLE  | ready for a command, register held
// LOAD  | one cycle of parallel load (LOAD data or ZERO)
// SHIFT | shifting/rotating, cnt holds remaining cycles
// DONE  | one-cycle completion (and err for reserved op)
module uni_register_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] q_in,
    output logic [1:0]       modo,
    output logic             serder,
    output logic             serizq,
    output logic [WIDTH-1:0] entparalela,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHU  = 3'd2;
    localparam logic [2:0] OP_SHD  = 3'd3;
    localparam logic [2:0] OP_ROTU = 3'd4;
    localparam logic [2:0] OP_ROTD = 3'd5;
    localparam logic [2:0] OP_ZERO = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam logic [1:0] MODO_HOLD = 2'd0;
    localparam logic [1:0] MODO_UP   = 2'd1;
    localparam logic [1:0] MODO_DOWN = 2'd2;
    localparam logic [1:0] MODO_LOAD = 2'd3;

    state_t             state, state_next;
    logic [2:0]         op_q, op_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [1:0]         modo_next;
    logic [WIDTH-1:0]   ent_next;
    logic               done_next;
    logic               err_next;
    logic               q_unused;

    // Rotation only needs the end bits of Q.
    assign q_unused = ^q_in[WIDTH-2:1];

    function automatic logic [1:0] shift_dir(input logic [2:0] op);
        return (op == OP_SHU || op == OP_ROTU) ? MODO_UP : MODO_DOWN;
    endfunction

    always_comb begin
        state_next = state;
        op_next    = op_q;
        cnt_next   = cnt;
        modo_next  = MODO_HOLD;
        ent_next   = '0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next  = cmd_op;
                    cnt_next = cmd_count;
                    case (cmd_op)
                        OP_LOAD: begin
                            state_next = ST_LOAD;
                            modo_next  = MODO_LOAD;
                            ent_next   = cmd_data;
                        end
                        OP_ZERO: begin
                            state_next = ST_LOAD;
                            modo_next  = MODO_LOAD;
                        end
                        OP_SHU, OP_SHD, OP_ROTU, OP_ROTD: begin
                            if (cmd_count != '0) begin
                                state_next = ST_SHIFT;
                                modo_next  = shift_dir(cmd_op);
                            end else begin
                                state_next = ST_DONE;
                                done_next  = 1'b1;
                            end
                        end
                        default: begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                            err_next   = (cmd_op == OP_RSVD);
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_next = ST_DONE;
                done_next  = 1'b1;
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next  = cnt - CNT_W'(1);
                    modo_next = shift_dir(op_q);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= ST_IDLE;
            op_q        <= OP_NOP;
            cnt         <= '0;
            modo        <= MODO_HOLD;
            entparalela <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            op_q        <= op_next;
            cnt         <= cnt_next;
            modo        <= modo_next;
            entparalela <= ent_next;
            done        <= done_next;
            err         <= err_next;
        end
    end

    // Serial inputs are combinational so rotates see Q as updated at the last falling edge.
    always_comb begin
        serder = 1'b0;
        serizq = 1'b0;
        if (state == ST_SHIFT) begin
            case (op_q)
                OP_SHU:  serder = ser_in;
                OP_ROTU: serder = q_in[WIDTH-1];
                OP_SHD:  serizq = ser_in;
                OP_ROTD: serizq = q_in[0];
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uni_register_seq.sv
// Self-checking bench for uni_register_seq: a falling-edge register plant, a per-cycle
// expectation queue model, directed scenarios and a randomized command stream.
module tb_uni_register_seq;

    logic       clk;
    logic       clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_count;
    logic [3:0] cmd_data;
    logic       ser_in;
    logic [3:0] q_reg;
    logic [1:0] modo;
    logic       serder;
    logic       serizq;
    logic [3:0] entparalela;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit ser_rand = 1;

    uni_register_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
        .ser_in(ser_in), .q_in(q_reg), .modo(modo), .serder(serder), .serizq(serizq),
        .entparalela(entparalela), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per expected busy cycle: what the sequencer must show during that cycle.
    typedef struct {
        logic [1:0] modo;
        logic [3:0] ent;
        logic       done;
        logic       err;
        logic [2:0] op;
    } cyc_t;

    cyc_t mq[$];
    logic [3:0] q_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register plant: samples on the falling edge.
    initial q_reg = 4'b0000;
    always @(negedge clk) begin
        case (modo)
            2'd1: q_reg <= {q_reg[2:0], serder};
            2'd2: q_reg <= {serizq, q_reg[3:1]};
            2'd3: q_reg <= entparalela;
            default: q_reg <= q_reg;
        endcase
    end

    // Expected register content, from the command semantics alone.
    initial q_exp = 4'b0000;
    always @(negedge clk) begin
        if (mq.size() != 0) begin
            case (mq[0].modo)
                2'd3: q_exp <= mq[0].ent;
                2'd1: q_exp <= {q_exp[2:0], (mq[0].op == 3'd4) ? q_exp[3] : ser_in};
                2'd2: q_exp <= {(mq[0].op == 3'd5) ? q_exp[0] : ser_in, q_exp[3:1]};
                default: q_exp <= q_exp;
            endcase
        end
    end

    // Model: expand each accepted command into its sequence of expected cycles.
    always @(posedge clk) begin
        cyc_t c;
        if (clear) begin
            mq.delete();
        end else if (mq.size() != 0) begin
            void'(mq.pop_front());
        end else if (cmd_valid) begin
            c = '{modo: 2'd0, ent: 4'd0, done: 1'b0, err: 1'b0, op: cmd_op};
            if (cmd_op == 3'd1 || cmd_op == 3'd6) begin
                c.modo = 2'd3;
                c.ent  = (cmd_op == 3'd1) ? cmd_data : 4'd0;
                mq.push_back(c);
            end else if (cmd_op >= 3'd2 && cmd_op <= 3'd5) begin
                c.modo = (cmd_op == 3'd2 || cmd_op == 3'd4) ? 2'd1 : 2'd2;
                for (int i = 0; i < int'(cmd_count); i++) mq.push_back(c);
            end
            c.modo = 2'd0;
            c.ent  = 4'd0;
            c.done = 1'b1;
            c.err  = (cmd_op == 3'd7);
            mq.push_back(c);
        end
    end

    // Per-cycle compare of every output against the model.
    always @(posedge clk) begin
        cyc_t e;
        logic sd_e, si_e;
        #3;
        if (chk_en) begin
            e = (mq.size() != 0) ? mq[0] : '{modo: 2'd0, ent: 4'd0, done: 1'b0, err: 1'b0, op: 3'd0};
            sd_e = (e.modo == 2'd1) ? ((e.op == 3'd4) ? q_exp[3] : ser_in) : 1'b0;
            si_e = (e.modo == 2'd2) ? ((e.op == 3'd5) ? q_exp[0] : ser_in) : 1'b0;
            check("modo", 32'(modo), 32'(e.modo));
            check("entparalela", 32'(entparalela), 32'(e.ent));
            check("done", 32'(done), 32'(e.done));
            check("err", 32'(err), 32'(e.err));
            check("busy", 32'(busy), 32'(mq.size() != 0));
            check("cmd_ready", 32'(cmd_ready), 32'(mq.size() == 0));
            check("serder", 32'(serder), 32'(sd_e));
            check("serizq", 32'(serizq), 32'(si_e));
            check("q", 32'(q_reg), 32'(q_exp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (ser_rand) ser_in = 1'($urandom_range(0, 1));
    endtask

    // Present a command and hold it until it is taken at an edge with cmd_ready high.
    task automatic send(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data);
        bit rdy;
        bit accepted;
        cmd_op = op;
        cmd_count = cnt;
        cmd_data = data;
        cmd_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 64 && !accepted; i++) begin
            #8;
            rdy = cmd_ready && !clear;
            step();
            if (rdy) accepted = 1;
        end
        cmd_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got not accepted expected accepted at %0t", $time);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && !cmd_ready; i++) step();
    endtask

    initial begin
        clear = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_count = 3'd0;
        cmd_data = 4'b1111;
        ser_in = 1'b0;

        // Reset held two cycles with a command offered
        step();
        chk_en = 1;
        step();
        check("rst_modo", 32'(modo), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        clear = 1'b0;
        cmd_valid = 1'b0;
        step();
        check("rst_no_accept", 32'(busy), 32'd0);

        // LOAD 1010
        send(3'd1, 3'd0, 4'b1010);
        check("load_modo", 32'(modo), 32'd3);
        check("load_ent", 32'(entparalela), 32'b1010);
        step();
        check("load_q", 32'(q_reg), 32'b1010);
        check("load_done", 32'(done), 32'd1);
        check("load_modo_off", 32'(modo), 32'd0);
        step();
        check("load_ready", 32'(cmd_ready), 32'd1);

        // SHU 3 with ser_in=1 from 1010
        ser_rand = 0;
        ser_in = 1'b1;
        send(3'd2, 3'd3, 4'd0);
        step();
        check("shu_q1", 32'(q_reg), 32'b0101);
        step();
        check("shu_q2", 32'(q_reg), 32'b1011);
        step();
        check("shu_q3", 32'(q_reg), 32'b0111);
        check("shu_done", 32'(done), 32'd1);
        ser_rand = 1;
        wait_idle();

        // ROTD 4 from 1001, with an ignored command pulse while busy
        send(3'd1, 3'd0, 4'b1001);
        wait_idle();
        send(3'd5, 3'd4, 4'd0);
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_data = 4'b1111;
        step();
        cmd_valid = 1'b0;
        check("rotd_q1", 32'(q_reg), 32'b1100);
        check("rotd_serizq", 32'(serizq), 32'd0);
        step();
        check("rotd_q2", 32'(q_reg), 32'b0110);
        step();
        check("rotd_q3", 32'(q_reg), 32'b0011);
        step();
        check("rotd_q4", 32'(q_reg), 32'b1001);
        check("rotd_done", 32'(done), 32'd1);
        wait_idle();

        // Degenerate ops
        send(3'd3, 3'd0, 4'd0);
        check("shd0_done", 32'(done), 32'd1);
        check("shd0_modo", 32'(modo), 32'd0);
        step();
        check("shd0_q", 32'(q_reg), 32'b1001);
        wait_idle();
        send(3'd7, 3'd5, 4'd0);
        check("op7_done", 32'(done), 32'd1);
        check("op7_err", 32'(err), 32'd1);
        step();
        check("op7_err_pulse", 32'(err), 32'd0);
        check("op7_q", 32'(q_reg), 32'b1001);
        wait_idle();

        // Abort SHU 7 after three shift cycles
        send(3'd6, 3'd0, 4'b1111);
        wait_idle();
        check("zero_q", 32'(q_reg), 32'b0000);
        ser_rand = 0;
        ser_in = 1'b1;
        send(3'd2, 3'd7, 4'd0);
        step();
        step();
        check("abort_modo_pre", 32'(modo), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("abort_modo", 32'(modo), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        step();
        check("abort_q", 32'(q_reg), 32'b0111);
        check("abort_no_done", 32'(done), 32'd0);
        ser_rand = 1;

        // Randomized command stream
        for (int n = 0; n < 250; n++) begin
            int r;
            repeat ($urandom_range(0, 3)) step();
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            r = $urandom_range(0, 9);
            if (r == 0) begin
                repeat ($urandom_range(0, 3)) step();
                clear = 1'b1;
                step();
                clear = 1'b0;
            end else if (r == 1) begin
                cmd_op = 3'($urandom_range(0, 7));
                cmd_count = 3'($urandom_range(0, 7));
                cmd_data = 4'($urandom_range(0, 15));
                cmd_valid = 1'b1;
                step();
                cmd_valid = 1'b0;
            end
        end
        wait_idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
